// File: rtl/issue_hazard_controller_if.sv
// Decode/scoreboard handshake bundle for the issue hazard controller.
// The controller connects through the slave modport, its driver through the master modport.
interface issue_hazard_controller_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             de_valid;
    logic             de_uses_src_a;
    logic             de_uses_src_b;
    logic [2:0]       de_src_a;
    logic [2:0]       de_src_b;
    logic             de_uses_dest;
    logic [2:0]       de_dest;
    logic             de_is_branch;
    logic [7:0]       sb_ready;
    logic             mem_stall;
    logic             wb_valid;
    logic             br_resolve;
    logic             br_taken;
    logic             issue;
    logic             stall;
    logic             alloc_en;
    logic [2:0]       alloc_idx;
    logic             release_en;
    logic [2:0]       release_idx;
    logic             flushing;
    logic [CNT_W-1:0] inflight;

    modport master (
        output de_valid, de_uses_src_a, de_uses_src_b, de_src_a, de_src_b,
               de_uses_dest, de_dest, de_is_branch, sb_ready, mem_stall,
               wb_valid, br_resolve, br_taken,
        input  issue, stall, alloc_en, alloc_idx, release_en, release_idx,
               flushing, inflight
    );

    modport slave (
        input  de_valid, de_uses_src_a, de_uses_src_b, de_src_a, de_src_b,
               de_uses_dest, de_dest, de_is_branch, sb_ready, mem_stall,
               wb_valid, br_resolve, br_taken,
        output issue, stall, alloc_en, alloc_idx, release_en, release_idx,
               flushing, inflight
    );
endinterface

// File: rtl/issue_hazard_controller.sv
// LC-3b decode issue controller: hazard checks, in-flight dest FIFO, wrong-path squash walk.
// Optional performance counters are enabled by defining ISSUE_HAZARD_PERF_EN.
module issue_hazard_controller #(
    parameter int DEPTH  = 4,
    parameter int PERF_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    issue_hazard_controller_if.slave   bus
`ifdef ISSUE_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]          perf_stall_cycles,
    output logic [PERF_W-1:0]          perf_flush_entries
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PERF_W < 1) begin : g_bad_param
        $error("issue_hazard_controller: DEPTH must be a power of two >= 2, PERF_W >= 1");
    end

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, br_ptr_q, br_ptr_d;
    logic          branch_pending_q, branch_pending_d;
    logic [3:0]    fifo_q [DEPTH];
    logic [3:0]    fifo_d [DEPTH];

    logic [PW-1:0] count, tail_m1;
    logic          full, empty, srcs_ok, dest_ok, can_issue;
    logic          retire, squash, resolve_taken, younger_exist;
    logic [3:0]    head_entry, last_entry;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count         = tail_q - head_q;
    assign tail_m1       = tail_q - 1'b1;
    assign full          = (count == PW'(DEPTH));
    assign empty         = (count == '0);
    assign head_entry    = fifo_q[head_q[AW-1:0]];
    assign last_entry    = fifo_q[tail_m1[AW-1:0]];
    assign retire        = bus.wb_valid && !empty;
    assign squash        = (state_q == FLUSH) && !retire;
    assign resolve_taken = bus.br_resolve && bus.br_taken && branch_pending_q;
    assign younger_exist = (tail_m1 != br_ptr_q);

    assign srcs_ok = (!bus.de_uses_src_a || bus.sb_ready[bus.de_src_a]) &&
                     (!bus.de_uses_src_b || bus.sb_ready[bus.de_src_b]);
    assign dest_ok = !bus.de_uses_dest || bus.sb_ready[bus.de_dest];

    assign can_issue = !rst && (state_q == RUN) && bus.de_valid && !bus.mem_stall &&
                       !full && srcs_ok && dest_ok &&
                       !(bus.de_is_branch && branch_pending_q) &&
                       !(bus.br_resolve && bus.br_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            head_q           <= '0;
            tail_q           <= '0;
            br_ptr_q         <= '0;
            branch_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            br_ptr_q         <= br_ptr_d;
            branch_pending_q <= branch_pending_d;
        end
    end

    // Entry storage needs no reset: validity is defined by the pointers alone.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (resolve_taken && younger_exist) state_d = FLUSH;
            FLUSH:   if (squash && ((tail_m1 - 1'b1) == br_ptr_q)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        br_ptr_d         = br_ptr_q;
        branch_pending_d = branch_pending_q;
        fifo_d           = fifo_q;
        if (retire) head_d = head_q + 1'b1;
        if (can_issue) begin
            tail_d = tail_q + 1'b1;
            fifo_d[tail_q[AW-1:0]] = {bus.de_uses_dest, bus.de_dest};
            if (bus.de_is_branch) begin
                br_ptr_d         = tail_q;
                branch_pending_d = 1'b1;
            end
        end else if (squash) begin
            tail_d = tail_m1;
        end
        if (bus.br_resolve && branch_pending_q) branch_pending_d = 1'b0;
    end

    always_comb begin
        bus.issue       = can_issue;
        bus.stall       = bus.de_valid && !can_issue;
        bus.alloc_en    = can_issue && bus.de_uses_dest;
        bus.alloc_idx   = bus.de_dest;
        bus.release_en  = 1'b0;
        bus.release_idx = 3'd0;
        bus.flushing    = (state_q == FLUSH);
        bus.inflight    = count;
        // Retire owns the release port; a flush step simply waits a cycle.
        if (retire) begin
            bus.release_en  = head_entry[3];
            bus.release_idx = head_entry[2:0];
        end else if (squash) begin
            bus.release_en  = last_entry[3];
            bus.release_idx = last_entry[2:0];
        end
    end

`ifdef ISSUE_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_cycles_q, perf_stall_cycles_d;
    logic [PERF_W-1:0] perf_flush_entries_q, perf_flush_entries_d;

    always_comb begin
        perf_stall_cycles_d  = perf_stall_cycles_q;
        perf_flush_entries_d = perf_flush_entries_q;
        if (bus.stall && !(&perf_stall_cycles_q))
            perf_stall_cycles_d = perf_stall_cycles_q + 1'b1;
        if (squash && !(&perf_flush_entries_q))
            perf_flush_entries_d = perf_flush_entries_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles_q  <= '0;
            perf_flush_entries_q <= '0;
        end else begin
            perf_stall_cycles_q  <= perf_stall_cycles_d;
            perf_flush_entries_q <= perf_flush_entries_d;
        end
    end

    assign perf_stall_cycles  = perf_stall_cycles_q;
    assign perf_flush_entries = perf_flush_entries_q;
`endif
endmodule

// File: tb/tb_issue_hazard_controller.sv
// Directed bench for issue_hazard_controller: expected outputs queued per step, popped and
// checked mid-cycle against the combinational/registered outputs.
module tb_issue_hazard_controller;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_hazard_controller_if #(.DEPTH(DEPTH)) bus ();

`ifdef ISSUE_HAZARD_PERF_EN
    logic [15:0] perf_stall_cycles, perf_flush_entries;
`endif

    issue_hazard_controller #(.DEPTH(DEPTH), .PERF_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ISSUE_HAZARD_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_entries(perf_flush_entries)
`endif
    );

    typedef struct {
        string      tag;
        logic       iss;
        logic       stl;
        logic       aen;
        logic [2:0] aidx;
        logic       ren;
        logic [2:0] ridx;
        logic       fl;
        logic [2:0] inf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input string field, input logic [7:0] got,
                       input logic [7:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, got, want);
        end
    endtask

    task automatic idle();
        bus.de_valid      = 1'b0;
        bus.de_uses_src_a = 1'b0;
        bus.de_uses_src_b = 1'b0;
        bus.de_src_a      = 3'd0;
        bus.de_src_b      = 3'd0;
        bus.de_uses_dest  = 1'b0;
        bus.de_dest       = 3'd0;
        bus.de_is_branch  = 1'b0;
        bus.sb_ready      = 8'hFF;
        bus.mem_stall     = 1'b0;
        bus.wb_valid      = 1'b0;
        bus.br_resolve    = 1'b0;
        bus.br_taken      = 1'b0;
    endtask

    task automatic ins(input logic ud, input logic [2:0] d, input logic ua,
                       input logic [2:0] a, input logic br);
        bus.de_valid      = 1'b1;
        bus.de_uses_dest  = ud;
        bus.de_dest       = d;
        bus.de_uses_src_a = ua;
        bus.de_src_a      = a;
        bus.de_is_branch  = br;
    endtask

    // Push expectation, let outputs settle, pop and compare, then move to the next negedge.
    task automatic step(input string tag, input logic iss, input logic stl, input logic aen,
                        input logic [2:0] aidx, input logic ren, input logic [2:0] ridx,
                        input logic fl, input logic [2:0] inf);
        exp_t e;
        exp_t g;
        e.tag = tag; e.iss = iss; e.stl = stl; e.aen = aen; e.aidx = aidx;
        e.ren = ren; e.ridx = ridx; e.fl = fl; e.inf = inf;
        exp_q.push_back(e);
        #2;
        g = exp_q.pop_front();
        chk(g.tag, "issue",      8'(bus.issue),      8'(g.iss));
        chk(g.tag, "stall",      8'(bus.stall),      8'(g.stl));
        chk(g.tag, "alloc_en",   8'(bus.alloc_en),   8'(g.aen));
        if (g.aen) chk(g.tag, "alloc_idx", 8'(bus.alloc_idx), 8'(g.aidx));
        chk(g.tag, "release_en", 8'(bus.release_en), 8'(g.ren));
        if (g.ren) chk(g.tag, "release_idx", 8'(bus.release_idx), 8'(g.ridx));
        chk(g.tag, "flushing",   8'(bus.flushing),   8'(g.fl));
        chk(g.tag, "inflight",   8'(bus.inflight),   8'(g.inf));
        $display("[%0t] %-12s issue=%0b stall=%0b alloc=%0b/%0d release=%0b/%0d flush=%0b inflight=%0d",
                 $time, g.tag, bus.issue, bus.stall, bus.alloc_en, bus.alloc_idx,
                 bus.release_en, bus.release_idx, bus.flushing, bus.inflight);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.de_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step("reset", 0, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // ADD R1 <- R2, R3
        idle(); ins(1, 3'd1, 1, 3'd2, 0); bus.de_uses_src_b = 1'b1; bus.de_src_b = 3'd3;
        step("add_r1", 1, 0, 1, 3'd1, 0, 0, 0, 0);
        idle(); ins(1, 3'd7, 1, 3'd1, 0); bus.sb_ready = 8'hFD;
        step("raw_stall", 0, 1, 0, 0, 0, 0, 0, 1);
        idle(); ins(1, 3'd7, 1, 3'd1, 0); bus.sb_ready = 8'hFD; bus.wb_valid = 1'b1;
        step("retire_r1", 0, 1, 0, 0, 1, 3'd1, 0, 1);
        idle(); ins(1, 3'd7, 1, 3'd1, 0);
        step("raw_clear", 1, 0, 1, 3'd7, 0, 0, 0, 0);
        idle(); bus.wb_valid = 1'b1;
        step("retire_r7", 0, 0, 0, 0, 1, 3'd7, 0, 1);

        // Fill the FIFO, then the fifth must wait even with a retire in that cycle
        for (int i = 0; i < 4; i++) begin
            idle(); ins(1, 3'(i), 0, 3'd0, 0);
            step("fill", 1, 0, 1, 3'(i), 0, 0, 0, 3'(i));
        end
        idle(); ins(1, 3'd4, 0, 3'd0, 0); bus.wb_valid = 1'b1;
        step("full_wb", 0, 1, 0, 0, 1, 3'd0, 0, 4);
        idle(); ins(1, 3'd4, 0, 3'd0, 0);
        step("full_next", 1, 0, 1, 3'd4, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            idle(); bus.wb_valid = 1'b1;
            step("drain", 0, 0, 0, 0, 1, 3'(i + 1), 0, 3'(4 - i));
        end
        idle(); bus.wb_valid = 1'b1;
        step("wb_empty", 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 3'd4, 0, 3'd0, 0); bus.sb_ready = 8'hEF;
        step("waw", 0, 1, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 3'd4, 0, 3'd0, 0); bus.mem_stall = 1'b1;
        step("mem_stall", 0, 1, 0, 0, 0, 0, 0, 0);

        // Taken branch squashes R4, R5 youngest first
        idle(); ins(0, 3'd0, 1, 3'd0, 1);
        step("br_issue", 1, 0, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 3'd4, 0, 3'd0, 0);
        step("wp_r4", 1, 0, 1, 3'd4, 0, 0, 0, 1);
        idle(); ins(0, 3'd0, 0, 3'd0, 1);
        step("br2_block", 0, 1, 0, 0, 0, 0, 0, 2);
        idle(); ins(1, 3'd5, 0, 3'd0, 0);
        step("wp_r5", 1, 0, 1, 3'd5, 0, 0, 0, 2);
        idle(); ins(1, 3'd6, 0, 3'd0, 0); bus.br_resolve = 1'b1; bus.br_taken = 1'b1;
        step("resolve_tk", 0, 1, 0, 0, 0, 0, 0, 3);
        idle();
        step("flush_r5", 0, 0, 0, 0, 1, 3'd5, 1, 3);
        step("flush_r4", 0, 0, 0, 0, 1, 3'd4, 1, 2);
        step("flush_done", 0, 0, 0, 0, 0, 0, 0, 1);
        idle(); bus.wb_valid = 1'b1;
        step("retire_br", 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        step("empty", 0, 0, 0, 0, 0, 0, 0, 0);

        // Not-taken branch: no flush, issue continues in the resolve cycle
        idle(); ins(0, 3'd0, 0, 3'd0, 1);
        step("br_nt", 1, 0, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 3'd2, 0, 3'd0, 0);
        step("nt_r2", 1, 0, 1, 3'd2, 0, 0, 0, 1);
        idle(); ins(1, 3'd3, 0, 3'd0, 0); bus.br_resolve = 1'b1;
        step("resolve_nt", 1, 0, 1, 3'd3, 0, 0, 0, 2);
        idle();
        step("nt_run", 0, 0, 0, 0, 0, 0, 0, 3);
        idle(); bus.wb_valid = 1'b1;
        step("nt_ret_br", 0, 0, 0, 0, 0, 0, 0, 3);
        step("nt_ret_r2", 0, 0, 0, 0, 1, 3'd2, 0, 2);
        step("nt_ret_r3", 0, 0, 0, 0, 1, 3'd3, 0, 1);

        // Retire in first flush cycle pauses the walk
        idle(); ins(1, 3'd6, 0, 3'd0, 0);
        step("old_r6", 1, 0, 1, 3'd6, 0, 0, 0, 0);
        idle(); ins(0, 3'd0, 0, 3'd0, 1);
        step("br_b", 1, 0, 0, 0, 0, 0, 0, 1);
        idle(); ins(1, 3'd4, 0, 3'd0, 0);
        step("wp_b_r4", 1, 0, 1, 3'd4, 0, 0, 0, 2);
        idle(); ins(1, 3'd5, 0, 3'd0, 0);
        step("wp_b_r5", 1, 0, 1, 3'd5, 0, 0, 0, 3);
        idle(); bus.br_resolve = 1'b1; bus.br_taken = 1'b1;
        step("resolve_b", 0, 0, 0, 0, 0, 0, 0, 4);
        idle(); bus.wb_valid = 1'b1;
        step("fl_retire", 0, 0, 0, 0, 1, 3'd6, 1, 4);
        idle();
        step("fl_b_r5", 0, 0, 0, 0, 1, 3'd5, 1, 3);
        step("fl_b_r4", 0, 0, 0, 0, 1, 3'd4, 1, 2);
        step("fl_b_done", 0, 0, 0, 0, 0, 0, 0, 1);
        idle(); bus.wb_valid = 1'b1;
        step("ret_br_b", 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset mid-flush aborts the walk immediately
        idle(); ins(0, 3'd0, 0, 3'd0, 1);
        step("br_c", 1, 0, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 3'd4, 0, 3'd0, 0);
        step("wp_c_r4", 1, 0, 1, 3'd4, 0, 0, 0, 1);
        idle(); ins(1, 3'd5, 0, 3'd0, 0);
        step("wp_c_r5", 1, 0, 1, 3'd5, 0, 0, 0, 2);
        idle(); bus.br_resolve = 1'b1; bus.br_taken = 1'b1;
        step("resolve_c", 0, 0, 0, 0, 0, 0, 0, 3);
        idle();
        step("fl_c_r5", 0, 0, 0, 0, 1, 3'd5, 1, 3);
        rst = 1'b1;
        step("rst_flush", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 3'd1, 0, 3'd0, 0);
        step("post_issue", 1, 0, 1, 3'd1, 0, 0, 0, 0);
        idle();
        step("post_count", 0, 0, 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
